// File: rtl/alu_ctrl_gen_if.sv
// Handshake and decoded-bundle signals between the fetch side, the ALU control
// generator and the execute-stage ALU.
interface alu_ctrl_gen_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [2:0]       alu_op;
    logic [1:0]       a_sel;
    logic             b_sel;
    logic [31:0]      imm;
    logic [2:0]       br_type;
    logic             wb_f;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_op, a_sel, b_sel, imm,
               br_type, wb_f, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_op, a_sel, b_sel, imm,
               br_type, wb_f, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_ctrl_gen.sv
// RV32I decode stage: turns an instruction word into registered ALU op/operand
// controls behind a one-deep valid/ready skid, and counts unexecutable encodings.
module alu_ctrl_gen #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_ctrl_gen_if.slave  bus
);
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [2:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [2:0]  br_type;
        logic        wb_f;
        logic        illegal;
    } bundle_t;

    logic [31:0]      instr_s;
    logic [6:0]       opcode_s;
    logic [2:0]       f3_s;
    logic [6:0]       f7_s;
    logic             f7_zero_s;
    logic             f7_alt_s;
    logic [31:0]      imm_i_s;
    logic [31:0]      imm_s_s;
    logic [31:0]      imm_b_s;
    logic [31:0]      imm_u_s;
    logic [31:0]      imm_j_s;
    logic [31:0]      shamt_s;
    logic [2:0]       alu_f3_s;
    logic             wb_f3_s;
    logic             r_ok_s;
    logic             i_ok_s;
    logic             accept_s;
    bundle_t          dec_s;

    bundle_t          bundle_r;
    logic             out_valid_r;
    logic [31:0]      pc_r;
    logic [CNT_W-1:0] cnt_r;

    assign instr_s   = bus.in_instr;
    assign opcode_s  = instr_s[6:0];
    assign f3_s      = instr_s[14:12];
    assign f7_s      = instr_s[31:25];
    assign f7_zero_s = (f7_s == F7_ZERO);
    assign f7_alt_s  = (f7_s == F7_ALT);

    assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s = {{20{instr_s[31]}}, instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    assign imm_u_s = {instr_s[31:12], 12'h000};
    assign imm_j_s = {{12{instr_s[31]}}, instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    assign shamt_s = {27'd0, instr_s[24:20]};

    // SUB via f7 only exists in the register form; ADDI's upper imm bits must not select it
    assign r_ok_s = (f3_s != 3'b011) &&
                    (f7_zero_s || (f7_alt_s && ((f3_s == 3'b000) || (f3_s == 3'b101))));
    assign i_ok_s = (f3_s != 3'b011) &&
                    ((f3_s == 3'b001) ? f7_zero_s :
                     (f3_s == 3'b101) ? (f7_zero_s || f7_alt_s) : 1'b1);

    // Shared funct3 to ALU op mapping for register and immediate arithmetic
    always_comb begin
        alu_f3_s = ALU_ADD;
        wb_f3_s  = 1'b0;
        case (f3_s)
            3'b000:  alu_f3_s = (f7_alt_s && (opcode_s == OPC_OP)) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_f3_s = ALU_SLL;
            3'b010: begin
                alu_f3_s = ALU_SUB;
                wb_f3_s  = 1'b1;
            end
            3'b100:  alu_f3_s = ALU_XOR;
            3'b101:  alu_f3_s = f7_alt_s ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3_s = ALU_OR;
            3'b111:  alu_f3_s = ALU_AND;
            default: alu_f3_s = ALU_ADD;
        endcase
    end

    // Full instruction decode; starts from the all-zero illegal bundle
    always_comb begin
        dec_s         = '0;
        dec_s.illegal = 1'b1;
        case (opcode_s)
            OPC_OP: begin
                if (r_ok_s) begin
                    dec_s.alu_op  = alu_f3_s;
                    dec_s.wb_f    = wb_f3_s;
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (i_ok_s) begin
                    dec_s.alu_op  = alu_f3_s;
                    dec_s.wb_f    = wb_f3_s;
                    dec_s.b_sel   = 1'b1;
                    dec_s.imm     = ((f3_s == 3'b001) || (f3_s == 3'b101)) ? shamt_s : imm_i_s;
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_s.b_sel   = 1'b1;
                dec_s.imm     = imm_i_s;
                dec_s.illegal = 1'b0;
            end
            OPC_JALR: begin
                if (f3_s == 3'b000) begin
                    dec_s.b_sel   = 1'b1;
                    dec_s.imm     = imm_i_s;
                    dec_s.br_type = 3'd5;
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_s.b_sel   = 1'b1;
                dec_s.imm     = imm_s_s;
                dec_s.illegal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_s.a_sel   = (opcode_s == OPC_LUI) ? 2'd2 : 2'd1;
                dec_s.b_sel   = 1'b1;
                dec_s.imm     = imm_u_s;
                dec_s.illegal = 1'b0;
            end
            OPC_JAL: begin
                dec_s.a_sel   = 2'd1;
                dec_s.b_sel   = 1'b1;
                dec_s.imm     = imm_j_s;
                dec_s.br_type = 3'd5;
                dec_s.illegal = 1'b0;
            end
            OPC_BRANCH: begin
                case (f3_s)
                    3'b000:  dec_s.br_type = 3'd1;
                    3'b001:  dec_s.br_type = 3'd2;
                    3'b100:  dec_s.br_type = 3'd3;
                    3'b101:  dec_s.br_type = 3'd4;
                    default: dec_s.br_type = 3'd0;
                endcase
                if (dec_s.br_type != 3'd0) begin
                    dec_s.alu_op  = ALU_SUB;
                    dec_s.imm     = imm_b_s;
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            default: dec_s.illegal = 1'b1;
        endcase
    end

    assign bus.in_ready = !out_valid_r || bus.out_ready;
    assign accept_s     = bus.in_valid && bus.in_ready;

    // Output bundle register: load on accept, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            bundle_r    <= '0;
            pc_r        <= 32'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            bundle_r    <= dec_s;
            pc_r        <= bus.in_pc;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of accepted illegal instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (accept_s && dec_s.illegal && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_pc      = pc_r;
    assign bus.alu_op      = bundle_r.alu_op;
    assign bus.a_sel       = bundle_r.a_sel;
    assign bus.b_sel       = bundle_r.b_sel;
    assign bus.imm         = bundle_r.imm;
    assign bus.br_type     = bundle_r.br_type;
    assign bus.wb_f        = bundle_r.wb_f;
    assign bus.illegal     = bundle_r.illegal;
    assign bus.illegal_cnt = cnt_r;
endmodule

// File: tb/tb_alu_ctrl_gen.sv
// Self-checking bench for alu_ctrl_gen: directed plan items followed by a
// randomized stream checked against an arithmetic reference decoder.
module tb_alu_ctrl_gen;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic [2:0]  br;
        logic        wbf;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cnt_model;
    exp_t exp_q[$];
    exp_t obs;
    logic obs_in_ready;

    alu_ctrl_gen_if #(.CNT_W(CNT_W)) bus ();

    alu_ctrl_gen #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference decoder built from field arithmetic rather than bit concatenation
    function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   opc, f3, f7, top, imm_i, imm_s, imm_b, imm_j;
        int   op_tab[8];
        bit   ok;
        op_tab = '{0, 5, 1, 0, 4, 6, 3, 2};
        opc   = int'(w[6:0]);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        top   = w[31] ? -1 : 0;
        imm_i = top * 4096 + int'(w[31:20]) - (w[31] ? 0 : 0) - (w[31] ? 4096 : 0) + (w[31] ? 4096 : 0);
        imm_i = (top * 4096) + int'(w[30:20]) + (w[31] ? 2048 : 0) - (w[31] ? 2048 : 0);
        imm_i = w[31] ? int'(w[31:20]) - 4096 : int'(w[31:20]);
        imm_s = top * 4096 + int'(w[31:25]) * 32 + int'(w[11:7]) + (w[31] ? 0 : 0);
        imm_s = w[31] ? (int'(w[31:25]) * 32 + int'(w[11:7]) - 4096) : (int'(w[31:25]) * 32 + int'(w[11:7]));
        imm_b = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm_j = top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        e    = '0;
        e.pc = pc;
        ok   = 1'b1;
        case (opc)
            'h33: begin
                ok    = (f3 != 3) && (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
                e.op  = 3'(op_tab[f3] + ((f7 == 32) ? 1 : 0));
                e.wbf = (f3 == 2);
            end
            'h13: begin
                ok    = (f3 != 3) && ((f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1);
                e.op  = 3'(op_tab[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
                e.wbf = (f3 == 2);
                e.b   = 1'b1;
                e.imm = (f3 == 1 || f3 == 5) ? 32'(int'(w[24:20])) : 32'(imm_i);
            end
            'h03: begin e.b = 1'b1; e.imm = 32'(imm_i); end
            'h67: begin ok = (f3 == 0); e.b = 1'b1; e.imm = 32'(imm_i); e.br = 3'd5; end
            'h23: begin e.b = 1'b1; e.imm = 32'(imm_s); end
            'h37: begin e.a = 2'd2; e.b = 1'b1; e.imm = w & 32'hFFFF_F000; end
            'h17: begin e.a = 2'd1; e.b = 1'b1; e.imm = w & 32'hFFFF_F000; end
            'h6F: begin e.a = 2'd1; e.b = 1'b1; e.imm = 32'(imm_j); e.br = 3'd5; end
            'h63: begin
                ok    = (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5);
                e.op  = 3'd1;
                e.imm = 32'(imm_b);
                e.br  = (f3 == 0) ? 3'd1 : (f3 == 1) ? 3'd2 : (f3 == 4) ? 3'd3 : 3'd4;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e    = '0;
            e.ill = 1'b1;
            e.pc = pc;
        end
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, check outputs and model, record accepts
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        #1;
        obs = '{op: bus.alu_op, a: bus.a_sel, b: bus.b_sel, imm: bus.imm, br: bus.br_type,
                wbf: bus.wb_f, ill: bus.illegal, pc: bus.out_pc};
        obs_in_ready = bus.in_ready;
        chk("in_ready", 64'(bus.in_ready), 64'((exp_q.size() == 0) || rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        chk("illegal_cnt", 64'(bus.illegal_cnt), 64'(cnt_model));
        if (bus.out_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("alu_op", 64'(obs.op), 64'(e.op));
            chk("a_sel", 64'(obs.a), 64'(e.a));
            chk("b_sel", 64'(obs.b), 64'(e.b));
            chk("imm", 64'(obs.imm), 64'(e.imm));
            chk("br_type", 64'(obs.br), 64'(e.br));
            chk("wb_f", 64'(obs.wbf), 64'(e.wbf));
            chk("illegal", 64'(obs.ill), 64'(e.ill));
            chk("out_pc", 64'(obs.pc), 64'(e.pc));
            if (rdy) void'(exp_q.pop_front());
        end
        if (v && ((exp_q.size() == 0) || rdy || bus.in_ready)) begin
            if (bus.in_ready) begin
                e = ref_model(ins, pc);
                exp_q.push_back(e);
                if (e.ill && cnt_model < CNT_MAX) cnt_model++;
            end
        end
    endtask

    logic [31:0] w;
    logic [6:0]  opcs [9];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cnt_model = 0;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63};
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_imm", 64'(bus.imm), 64'd0);
        chk("rst_cnt", 64'(bus.illegal_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // sub x0,x1,x2
        cycle(1'b1, 32'h4020_8033, 32'h0000_0000, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_op", 64'(obs.op), 64'd1);
        chk("t1_bsel", 64'(obs.b), 64'd0);
        chk("t1_ill", 64'(obs.ill), 64'd0);
        // xori then srai back to back
        cycle(1'b1, 32'hFFF0_C093, 32'h0000_0004, 1'b1);
        cycle(1'b1, 32'h4010_D093, 32'h0000_0008, 1'b1);
        chk("t2_xori_op", 64'(obs.op), 64'd4);
        chk("t2_xori_imm", 64'(obs.imm), 64'hFFFF_FFFF);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t2_srai_op", 64'(obs.op), 64'd7);
        chk("t2_srai_imm", 64'(obs.imm), 64'd1);
        // lui / auipc
        cycle(1'b1, 32'h1234_5037, 32'h0000_0100, 1'b1);
        cycle(1'b1, 32'h1234_5017, 32'h0000_0104, 1'b1);
        chk("t3_lui_asel", 64'(obs.a), 64'd2);
        chk("t3_lui_imm", 64'(obs.imm), 64'h1234_5000);
        chk("t3_lui_pc", 64'(obs.pc), 64'h100);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t3_auipc_asel", 64'(obs.a), 64'd1);
        // blt, then sltu (illegal)
        cycle(1'b1, 32'hFE20_CEE3, 32'h0000_0200, 1'b1);
        cycle(1'b1, 32'h0020_B033, 32'h0000_0204, 1'b1);
        chk("t4_blt_op", 64'(obs.op), 64'd1);
        chk("t4_blt_br", 64'(obs.br), 64'd3);
        chk("t4_blt_imm", 64'(obs.imm), 64'hFFFF_FFFC);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t4_sltu_ill", 64'(obs.ill), 64'd1);
        chk("t4_sltu_cnt", 64'(bus.illegal_cnt), 64'd1);

        // stall for three cycles with a second instruction waiting
        cycle(1'b1, 32'h0020_80B3, 32'h0000_0300, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0041_0113, 32'h0000_0304, 1'b0);
            chk("t5_stall_ready", 64'(obs_in_ready), 64'd0);
            chk("t5_stall_pc", 64'(obs.pc), 64'h300);
        end
        cycle(1'b1, 32'h0041_0113, 32'h0000_0304, 1'b1);
        cycle(1'b1, 32'h0000_0073, 32'h0000_0308, 1'b1);
        chk("t5_release_pc", 64'(obs.pc), 64'h304);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);

        // saturation: five illegal words
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hFFFF_FFFF, 32'(32'h400 + 4 * i), 1'b1);
        cycle(1'b1, 32'h0000_0000, 32'h0000_0500, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t6_sat_cnt", 64'(bus.illegal_cnt), 64'd3);
        chk("t6_held_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_async_cnt", 64'(bus.illegal_cnt), 64'd0);
        chk("t6_async_pc", 64'(bus.out_pc), 64'd0);
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // randomized stream with random backpressure
        for (int i = 0; i < 600; i++) begin
            w = $urandom();
            if ($urandom_range(0, 9) < 8) w[6:0] = opcs[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            cycle(1'($urandom_range(0, 3) != 0), w, $urandom(), 1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
